// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping bus controller and the per-CPU coherency units.
package mesi_bus_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE, GRANT, WB, SNOOP, XFER, SUPP_WB, L2RD, DONE
  } bus_state_t;

  typedef enum logic [1:0] {
    MODIFIED, EXCLUSIVE, SHARED, INVALID
  } cc_end_state;

endpackage

// File: rtl/mesi_bus_ctrl_if.sv
// Bus between the MESI bus controller (master) and the coherency units plus L2 (slave).
interface mesi_bus_ctrl_if
  import mesi_bus_pkg::*;
#(
  parameter int unsigned CPUS       = 2,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned DW = BLOCK_SIZE * WORD_W;

  logic [CPUS-1:0]                 dREN, dWEN, ccwrite;
  logic [CPUS-1:0][ADDR_WIDTH-1:0] daddr;
  logic [CPUS-1:0][DW-1:0]         dstore;
  logic [CPUS-1:0]                 ccsnoopdone, ccsnoophit, ccdirty;
  logic [CPUS-1:0]                 dwait;
  logic [CPUS-1:0][DW-1:0]         dload;
  logic [CPUS-1:0]                 ccwait, ccinv, ccexclusive;
  logic [CPUS-1:0][ADDR_WIDTH-1:0] ccsnoopaddr;
  logic                            l2REN, l2WEN;
  logic [ADDR_WIDTH-1:0]           l2addr;
  logic [DW-1:0]                   l2store;
  logic [DW-1:0]                   l2load;
  logic                            l2busy;

  modport master (
    input  dREN, dWEN, ccwrite, daddr, dstore, ccsnoopdone, ccsnoophit, ccdirty,
           l2load, l2busy,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, ccexclusive,
           l2REN, l2WEN, l2addr, l2store
  );

  modport slave (
    output dREN, dWEN, ccwrite, daddr, dstore, ccsnoopdone, ccsnoophit, ccdirty,
           l2load, l2busy,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ccexclusive,
           l2REN, l2WEN, l2addr, l2store
  );

endinterface

// File: rtl/mesi_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins; pointer lives in the parent.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (advance && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Snooping MESI bus controller: serialises one coherency transaction at a time across CPUS
// cores, routing cache-to-cache transfers and falling back to the shared L2 port.
module mesi_bus_ctrl
  import mesi_bus_pkg::*;
#(
  parameter int unsigned CPUS       = 2,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic            CLK,
  input logic            RST,
  mesi_bus_ctrl_if.master bus
);

  localparam int unsigned DW = BLOCK_SIZE * WORD_W;
  localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  bus_state_t state, next_state;
  logic [IW-1:0] req_q, req_d, ptr_q, ptr_d, sup_q, sup_d, gnt_idx;
  logic          sup_dirty_q, sup_dirty_d;
  logic [CPUS-1:0] reqs, gnt, req_oh, others, hits;
  logic            snoop_done;

  logic [CPUS-1:0]                 dwait_d, ccwait_d, ccinv_d, ccexcl_d;
  logic [CPUS-1:0][ADDR_WIDTH-1:0] snaddr_d;
  logic [CPUS-1:0][DW-1:0]         dload_d;
  logic                            l2ren_d, l2wen_d;
  logic [ADDR_WIDTH-1:0]           l2addr_d;
  logic [DW-1:0]                   l2store_d;

  assign reqs       = bus.dREN | bus.dWEN;
  assign req_oh     = CPUS'(1) << req_q;
  assign others     = ~req_oh;
  assign snoop_done = &(bus.ccsnoopdone | req_oh);
  assign hits       = bus.ccsnoophit & others;

  rr_arbiter #(.N(CPUS)) u_arb (
    .req     (reqs),
    .ptr     (ptr_q),
    .advance (state == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Next state plus next value of every registered output; outputs line up with the state they belong to.
  always_comb begin
    next_state  = state;
    req_d       = req_q;
    ptr_d       = ptr_q;
    sup_d       = sup_q;
    sup_dirty_d = sup_dirty_q;
    dwait_d     = '1;
    ccwait_d    = bus.ccwait;
    ccinv_d     = bus.ccinv;
    ccexcl_d    = bus.ccexclusive;
    snaddr_d    = bus.ccsnoopaddr;
    dload_d     = bus.dload;
    l2ren_d     = bus.l2REN;
    l2wen_d     = bus.l2WEN;
    l2addr_d    = bus.l2addr;
    l2store_d   = bus.l2store;

    unique case (state)
      IDLE: begin
        if (|gnt) begin
          req_d      = gnt_idx;
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (bus.dWEN[req_q]) begin
          next_state = WB;
          l2wen_d    = 1'b1;
          l2addr_d   = bus.daddr[req_q];
          l2store_d  = bus.dstore[req_q];
        end else if (CPUS == 1) begin
          next_state      = L2RD;
          l2ren_d         = 1'b1;
          l2addr_d        = bus.daddr[req_q];
          ccexcl_d[req_q] = !bus.ccwrite[req_q];
        end else begin
          next_state = SNOOP;
          ccwait_d   = others;
          ccinv_d    = others & {CPUS{bus.ccwrite[req_q]}};
          for (int i = 0; i < int'(CPUS); i++) begin
            if (others[i]) snaddr_d[i] = bus.daddr[req_q];
          end
        end
      end
      WB, SUPP_WB: begin
        if (!bus.l2busy) begin
          next_state = DONE;
          l2wen_d    = 1'b0;
        end
      end
      SNOOP: begin
        if (snoop_done) begin
          if (|hits) begin
            next_state = XFER;
            // Lowest-index hitter supplies the block.
            for (int i = int'(CPUS) - 1; i >= 0; i--) begin
              if (hits[i]) begin
                sup_d       = IW'(i);
                sup_dirty_d = bus.ccdirty[i];
              end
            end
          end else begin
            next_state      = L2RD;
            l2ren_d         = 1'b1;
            l2addr_d        = bus.daddr[req_q];
            ccexcl_d[req_q] = !bus.ccwrite[req_q];
          end
        end
      end
      XFER: begin
        dload_d[req_q] = bus.dstore[sup_q];
        ccexcl_d       = '0;
        // A writer takes the M copy as-is, so only a reader forces the dirty block back to L2.
        if (sup_dirty_q && !bus.ccwrite[req_q]) begin
          next_state = SUPP_WB;
          l2wen_d    = 1'b1;
          l2addr_d   = bus.daddr[req_q];
          l2store_d  = bus.dstore[sup_q];
        end else begin
          next_state = DONE;
        end
      end
      L2RD: begin
        if (!bus.l2busy) begin
          next_state     = DONE;
          l2ren_d        = 1'b0;
          dload_d[req_q] = bus.l2load;
        end
      end
      DONE: begin
        next_state = IDLE;
        ccexcl_d   = '0;
        ptr_d      = IW'((32'(req_q) + 32'd1) % CPUS);
      end
      default: next_state = IDLE;
    endcase

    if (next_state == DONE && state != DONE) begin
      dwait_d[req_q] = 1'b0;
      ccwait_d       = '0;
      ccinv_d        = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      req_q           <= '0;
      ptr_q           <= '0;
      sup_q           <= '0;
      sup_dirty_q     <= 1'b0;
      bus.dwait       <= '1;
      bus.ccwait      <= '0;
      bus.ccinv       <= '0;
      bus.ccexclusive <= '0;
      bus.ccsnoopaddr <= '0;
      bus.dload       <= '0;
      bus.l2REN       <= 1'b0;
      bus.l2WEN       <= 1'b0;
      bus.l2addr      <= '0;
      bus.l2store     <= '0;
    end else begin
      state           <= next_state;
      req_q           <= req_d;
      ptr_q           <= ptr_d;
      sup_q           <= sup_d;
      sup_dirty_q     <= sup_dirty_d;
      bus.dwait       <= dwait_d;
      bus.ccwait      <= ccwait_d;
      bus.ccinv       <= ccinv_d;
      bus.ccexclusive <= ccexcl_d;
      bus.ccsnoopaddr <= snaddr_d;
      bus.dload       <= dload_d;
      bus.l2REN       <= l2ren_d;
      bus.l2WEN       <= l2wen_d;
      bus.l2addr      <= l2addr_d;
      bus.l2store     <= l2store_d;
    end
  end

endmodule
